// File: rtl/retire_trace_fifo.sv
// retire_trace_fifo: captures retired-instruction records from the core into a
// first-word-fall-through FIFO and replays them on a valid/ready trace stream.
// Every record carries a retire sequence number. Records that arrive while the
// FIFO is full are dropped and counted, so the core is never stalled.
module retire_trace_fifo #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 8,
   parameter int CNT_W = 32
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       clear_i,
   input  logic                       update_i,
   input  logic [XLEN-1:0]            pc_i,
   input  logic [XLEN-1:0]            instr_i,
   input  logic [4:0]                 reg_addr_i,
   input  logic [XLEN-1:0]            reg_data_i,
   input  logic [XLEN-1:0]            mem_addr_i,
   input  logic [XLEN-1:0]            mem_data_i,
   input  logic                       mem_wrt_i,
   input  logic                       mem_read_i,
   output logic                       trace_valid_o,
   input  logic                       trace_ready_i,
   output logic [CNT_W-1:0]           trace_seq_o,
   output logic [XLEN-1:0]            trace_pc_o,
   output logic [XLEN-1:0]            trace_instr_o,
   output logic [4:0]                 trace_reg_addr_o,
   output logic [XLEN-1:0]            trace_reg_data_o,
   output logic [XLEN-1:0]            trace_mem_addr_o,
   output logic [XLEN-1:0]            trace_mem_data_o,
   output logic                       trace_mem_wrt_o,
   output logic                       trace_mem_read_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic [CNT_W-1:0]           retire_cnt_o,
   output logic [CNT_W-1:0]           drop_cnt_o,
   output logic                       overflow_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef struct packed {
      logic [CNT_W-1:0] seq;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  instr;
      logic [4:0]       reg_addr;
      logic [XLEN-1:0]  reg_data;
      logic [XLEN-1:0]  mem_addr;
      logic [XLEN-1:0]  mem_data;
      logic             mem_wrt;
      logic             mem_read;
   } rec_t;

   rec_t             mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic             overflow_q, overflow_d;

   rec_t new_rec;
   rec_t head_rec;
   logic push, pop, full, accept, drop;

   // Build the incoming record; unused register and memory fields are zeroed.
   always_comb begin
      new_rec          = '0;
      new_rec.seq      = retire_cnt_q;
      new_rec.pc       = pc_i;
      new_rec.instr    = instr_i;
      new_rec.reg_addr = reg_addr_i;
      new_rec.reg_data = (reg_addr_i == 5'd0) ? '0 : reg_data_i;
      new_rec.mem_wrt  = mem_wrt_i;
      new_rec.mem_read = mem_read_i;
      if (mem_wrt_i || mem_read_i) begin
         new_rec.mem_addr = mem_addr_i;
         new_rec.mem_data = mem_data_i;
      end
   end

   // Handshake decode and next-state for pointers, level and counters.
   // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
   always_comb begin
      full         = (level_q == LVL_W'(DEPTH));
      push         = update_i && !clear_i;
      pop          = (level_q != '0) && trace_ready_i && !clear_i;
      accept       = push && (!full || pop);
      drop         = push && full && !pop;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      level_d      = level_q;
      retire_cnt_d = retire_cnt_q;
      drop_cnt_d   = drop_cnt_q;
      overflow_d   = overflow_q;
      if (clear_i) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         level_d      = '0;
         retire_cnt_d = '0;
         drop_cnt_d   = '0;
         overflow_d   = 1'b0;
      end else begin
         if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
         if (accept && !pop)      level_d = level_q + 1'b1;
         else if (pop && !accept) level_d = level_q - 1'b1;
         if (push) retire_cnt_d = retire_cnt_q + 1'b1;
         if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
         end
      end
   end

   // Control state with asynchronous reset.
   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         retire_cnt_q <= '0;
         drop_cnt_q   <= '0;
         overflow_q   <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         retire_cnt_q <= retire_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         overflow_q   <= overflow_d;
      end
   end

   // Record storage; written at the tail on every accepted push.
   // NOTE: the array has no reset; stale entries are never visible because outputs are gated by level.
   always_ff @(posedge clk_i) begin
      if (accept) mem_q[wr_ptr_q] <= new_rec;
   end

   // Head record drives the stream, forced to zero while the FIFO is empty.
   always_comb begin
      trace_valid_o = (level_q != '0);
      head_rec      = trace_valid_o ? mem_q[rd_ptr_q] : '0;
   end

   assign trace_seq_o      = head_rec.seq;
   assign trace_pc_o       = head_rec.pc;
   assign trace_instr_o    = head_rec.instr;
   assign trace_reg_addr_o = head_rec.reg_addr;
   assign trace_reg_data_o = head_rec.reg_data;
   assign trace_mem_addr_o = head_rec.mem_addr;
   assign trace_mem_data_o = head_rec.mem_data;
   assign trace_mem_wrt_o  = head_rec.mem_wrt;
   assign trace_mem_read_o = head_rec.mem_read;
   assign level_o          = level_q;
   assign retire_cnt_o     = retire_cnt_q;
   assign drop_cnt_o       = drop_cnt_q;
   assign overflow_o       = overflow_q;

endmodule
